// File: rtl/seg_display_pkg.sv
// Shared constants for the front-panel seven-segment display engine.
package seg_display_pkg;

    // Which of the four CPU words is on the display.
    typedef enum logic [1:0] {
        VIEW_LED    = 2'd0,
        VIEW_ALL    = 2'd1,
        VIEW_BRANCH = 2'd2,
        VIEW_JMP    = 2'd3
    } view_e;

    // All digits off / all segments off (common anode, active-low).
    localparam logic [7:0] BLANK = 8'hFF;

    // Active-low segment patterns, bit order g..a, indexed by nibble value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
module debounce_pulse #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [CNT_W-1:0] stable_cnt;

    // Bring the asynchronous button level into the clk domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYC cycles in a row.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            stable_cnt <= '0;
            level      <= 1'b0;
        end else if (sync2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            stable_cnt <= '0;
            level      <= ~level;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    // Delayed copy of the accepted level for edge detection.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // One-cycle pulse on each accepted press; releases produce nothing.
    assign press = level & ~level_q;

endmodule

// File: rtl/seg_scan_display.sv
// Scans one of four 32-bit CPU words across an 8-digit common-anode display.
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] Leddata,
    input  logic [31:0] Count_all,
    input  logic [31:0] Count_branch,
    input  logic [31:0] Count_jmp,
    input  logic        Sel_btn,
    output logic [7:0]  AN,
    output logic [7:0]  SEG,
    output logic [1:0]  View
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [2:0]       digit;
    logic [2:0]       digit_nxt;
    logic             frame_wrap;
    logic [31:0]      snap;
    logic [31:0]      snap_nxt;
    logic [31:0]      view_word;
    logic             blank;
    logic             blank_nxt;
    logic [3:0]       nibble;
    logic             dp_n;
    logic             btn_level;
    logic             btn_press;

    debounce_pulse #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_sel_btn (
        .clk   (clk),
        .clr   (clr),
        .raw   (Sel_btn),
        .level (btn_level),
        .press (btn_press)
    );

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    // Digit-slot divider: free-running 0..SCAN_DIV-1.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Each accepted press steps to the next view, 3 wrapping to 0.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            View <= VIEW_LED;
        end else if (btn_press) begin
            View <= View + 2'd1;
        end
    end

    // Next digit slot and the word it will show; a new frame captures the current view.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        view_word  = Leddata;
        digit_nxt  = digit + 3'd1;
        frame_wrap = (digit == 3'd7);
        case (view_e'(View))
            VIEW_LED:    view_word = Leddata;
            VIEW_ALL:    view_word = Count_all;
            VIEW_BRANCH: view_word = Count_branch;
            VIEW_JMP:    view_word = Count_jmp;
            default:     view_word = Leddata;
        endcase
        snap_nxt  = frame_wrap ? view_word : snap;
        blank_nxt = blank & ~frame_wrap;
        nibble    = snap_nxt[{digit_nxt, 2'b00} +: 4];
        dp_n      = (digit_nxt != View);
    end

    // Advance scan position, snapshot the word once per frame, register the drive pattern.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            digit <= 3'd7;
            snap  <= '0;
            blank <= 1'b1;
            AN    <= BLANK;
            SEG   <= BLANK;
        end else if (tick) begin
            digit <= digit_nxt;
            snap  <= snap_nxt;
            blank <= blank_nxt;
            if (blank_nxt) begin
                AN  <= BLANK;
                SEG <= BLANK;
            end else begin
                AN  <= ~(8'd1 << digit_nxt);
                SEG <= {dp_n, hex_to_seg(nibble)};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with SCAN_DIV=4, DEBOUNCE_CYC=8.
module tb_seg_scan_display;

    localparam int SD = 4;
    localparam int DB = 8;

    logic        clk;
    logic        clr;
    logic [31:0] Leddata;
    logic [31:0] Count_all;
    logic [31:0] Count_branch;
    logic [31:0] Count_jmp;
    logic        Sel_btn;
    logic [7:0]  AN;
    logic [7:0]  SEG;
    logic [1:0]  View;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    seg_scan_display #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .Leddata      (Leddata),
        .Count_all    (Count_all),
        .Count_branch (Count_branch),
        .Count_jmp    (Count_jmp),
        .Sel_btn      (Sel_btn),
        .AN           (AN),
        .SEG          (SEG),
        .View         (View)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    int          m_cyc;     // clock edges since reset release
    int          m_tick;    // digit slots started since reset release
    logic [31:0] m_snap;
    logic [1:0]  m_view;
    logic        m_acc;     // accepted button level
    int          m_run;     // consecutive cycles the synchronised level disagrees
    logic        m_pend;    // press accepted, view steps on the next edge
    logic        raw_q[$];  // last two raw samples (two-cycle synchroniser delay)
    logic [7:0]  m_an = 8'hFF;
    logic [7:0]  m_seg = 8'hFF;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_cyc  = 0;
            m_tick = 0;
            m_snap = '0;
            m_view = 2'd0;
            m_acc  = 1'b0;
            m_run  = 0;
            m_pend = 1'b0;
            m_an   = 8'hFF;
            m_seg  = 8'hFF;
            raw_q.delete();
            raw_q.push_back(1'b0);
            raw_q.push_back(1'b0);
        end else begin
            logic [1:0] v_old;
            logic       synced;
            int         d;
            v_old = m_view;
            if (m_cyc % SD == SD - 1) begin
                d = m_tick % 8;
                if (d == 0) begin
                    case (v_old)
                        2'd0:    m_snap = Leddata;
                        2'd1:    m_snap = Count_all;
                        2'd2:    m_snap = Count_branch;
                        default: m_snap = Count_jmp;
                    endcase
                end
                m_an  = ~(8'd1 << d);
                m_seg = {(d == int'(v_old)) ? 1'b0 : 1'b1, hex7(m_snap[4*d +: 4])};
                m_tick++;
            end
            m_cyc++;
            if (m_pend) m_view = m_view + 2'd1;
            m_pend = 1'b0;
            synced = raw_q.pop_front();
            raw_q.push_back(Sel_btn);
            if (synced != m_acc) begin
                m_run++;
                if (m_run == DB) begin
                    m_acc = ~m_acc;
                    m_run = 0;
                    if (m_acc) m_pend = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_an", {24'd0, AN}, {24'd0, m_an});
            check("model_seg", {24'd0, SEG}, {24'd0, m_seg});
            check("model_view", {30'd0, View}, {30'd0, m_view});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step_check(input string name, input logic [7:0] an_e, input logic [7:0] seg_e);
        check({name, "_an"}, {24'd0, AN}, {24'd0, an_e});
        check({name, "_seg"}, {24'd0, SEG}, {24'd0, seg_e});
    endtask

    // Wait for the next slot (not the current one) driving the given anode pattern.
    task automatic wait_an(input logic [7:0] target, input string name);
        int n = 0;
        while (AN == target && n < 64) begin
            @(posedge clk); #1; n++;
        end
        do begin
            @(posedge clk); #1; n++;
        end while (AN != target && n < 64);
        check({name, "_wait"}, {24'd0, AN}, {24'd0, target});
    endtask

    task automatic press_btn();
        @(posedge clk); #1 Sel_btn = 1'b1;
        repeat (20) @(posedge clk);
        #1 Sel_btn = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk) clr = 1'b1;
    endtask

    // Hand-computed first frame of 32'h1234ABCD with view 0 (dp on digit 0).
    logic [7:0] f1_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] f1_seg [8] = '{8'h21, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    initial begin
        clr          = 1'b0;
        Sel_btn      = 1'b0;
        Leddata      = 32'h1234ABCD;
        Count_all    = 32'h00000005;
        Count_branch = 32'h00C0FFEE;
        Count_jmp    = 32'h76543210;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #1;
        step_check("reset", 8'hFF, 8'hFF);
        check("reset_view", {30'd0, View}, 32'd0);

        // First frame after reset: blank until the tick at cycle 3.
        release_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            step_check("pre_tick", 8'hFF, 8'hFF);
        end
        @(posedge clk); #1;
        step_check("f1_d0", f1_an[0], f1_seg[0]);
        for (int d = 1; d < 8; d++) begin
            repeat (SD) @(posedge clk); #1;
            step_check("f1_digit", f1_an[d], f1_seg[d]);
        end

        // Second frame: change the word after digit 1; rest of frame keeps old nibbles.
        repeat (SD) @(posedge clk); #1;
        step_check("f2_d0", 8'hFE, 8'h21);
        repeat (SD) @(posedge clk); #1;
        step_check("f2_d1", 8'hFD, 8'hC6);
        Leddata = 32'hFFFFFFFF;
        repeat (SD) @(posedge clk); #1;
        step_check("f2_d2_old", 8'hFB, 8'h83);
        wait_an(8'hFE, "f3");
        check("f3_d0_seg", {24'd0, SEG}, 32'h0000000E);

        // Hold button 20 cycles: view steps once, 10 cycles after first high sample.
        @(posedge clk); #1 Sel_btn = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("hold_view_before", {30'd0, View}, 32'd0);
        @(posedge clk); #1;
        check("hold_view_after", {30'd0, View}, 32'd1);
        repeat (9) @(posedge clk); #1 Sel_btn = 1'b0;
        wait_an(8'hFE, "all_d0");
        check("all_d0_seg", {24'd0, SEG}, 32'h00000092);
        repeat (SD) @(posedge clk); #1;
        step_check("all_d1_dp", 8'hFD, 8'h40);
        repeat (20) @(posedge clk); #1;
        check("hold_view_after_release", {30'd0, View}, 32'd1);

        // Reset, then short glitches must not change the view.
        clr = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        for (int g = 0; g < 3; g++) begin
            @(posedge clk); #1 Sel_btn = 1'b1;
            repeat (5) @(posedge clk); #1 Sel_btn = 1'b0;
            repeat (10) @(posedge clk);
        end
        #1;
        check("glitch_view", {30'd0, View}, 32'd0);

        // Four clean presses: 1, 2, 3, 0.
        press_btn();
        check("press1_view", {30'd0, View}, 32'd1);
        press_btn();
        check("press2_view", {30'd0, View}, 32'd2);
        wait_an(8'hFE, "branch_d0");
        check("branch_d0_seg", {24'd0, SEG}, 32'h00000086);
        press_btn();
        check("press3_view", {30'd0, View}, 32'd3);
        wait_an(8'hFE, "jmp_d0");
        check("jmp_d0_seg", {24'd0, SEG}, 32'h000000C0);
        press_btn();
        check("press4_view", {30'd0, View}, 32'd0);

        // Reach view 2, then reset mid-frame.
        press_btn();
        press_btn();
        check("pre_reset_view", {30'd0, View}, 32'd2);
        repeat (6) @(posedge clk);
        #1 clr = 1'b0;
        #1;
        step_check("midreset", 8'hFF, 8'hFF);
        check("midreset_view", {30'd0, View}, 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            step_check("post_reset_blank", 8'hFF, 8'hFF);
        end
        @(posedge clk); #1;
        step_check("post_reset_d0", 8'hFE, 8'h0E);
        repeat (40) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
